// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook scheduler.
package cook_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } cook_state_e;

  localparam logic [6:0] MaxMin = 7'd99;
  localparam logic [6:0] MaxSec = 7'd59;

  localparam logic [1:0] PowerLow  = 2'd0;
  localparam logic [1:0] PowerMed  = 2'd1;
  localparam logic [1:0] PowerHigh = 2'd2;
  localparam logic [1:0] PowerFull = 2'd3;

  // Magnetron on-seconds per duty window: (power + 1) quarters of the window.
  function automatic int unsigned on_seconds(logic [1:0] power, int unsigned window);
    int unsigned secs;
    secs = window;
    unique case (power)
      PowerLow:  secs = window / 4;
      PowerMed:  secs = window / 2;
      PowerHigh: secs = (3 * window) / 4;
      PowerFull: secs = window;
      default:   secs = window;
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts enabled cycles and pulses tick on the terminal count.
module tick_gen #(
  parameter int unsigned ClkHz = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClkHz > 1) ? $clog2(ClkHz) : 1;
  localparam logic [CntW-1:0] Terminal = CntW'(ClkHz - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == Terminal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cook_scheduler.sv
// Countdown timer and power-duty gate for the magnetron; all outputs are registered.
module cook_scheduler
  import cook_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned WINDOW = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] min_in,
  input  logic [6:0] sec_in,
  input  logic [1:0] power_in,
  input  logic       run,
  input  logic       abort,
  output logic [6:0] min_out,
  output logic [6:0] sec_out,
  output logic       magnetron,
  output logic       busy,
  output logic       done
);

  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);

  cook_state_e     state_q, state_d;
  logic [6:0]      min_q, min_d;
  logic [6:0]      sec_q, sec_d;
  logic [WinW-1:0] win_q, win_d;
  logic [1:0]      power_q, power_d;
  logic            mag_q, mag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic tick_en, tick_clr, tick;

  // Prescaler only advances while actually cooking; abort wins over everything.
  assign tick_en = (state_q == StRun) && run && !abort;

  tick_gen #(
    .ClkHz(CLK_HZ)
  ) u_tick_gen (
    .clk_i (clock),
    .rst_ni(reset),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    win_d    = win_q;
    power_d  = power_q;
    tick_clr = 1'b0;

    if (abort) begin
      state_d  = StIdle;
      min_d    = '0;
      sec_d    = '0;
      win_d    = '0;
      power_d  = '0;
      tick_clr = 1'b1;
    end else if (load && (state_q == StIdle || state_q == StDone)) begin
      min_d   = (min_in > MaxMin) ? MaxMin : min_in;
      sec_d   = (sec_in > MaxSec) ? MaxSec : sec_in;
      power_d = power_in;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run && (min_q != '0 || sec_q != '0)) begin
            state_d  = StRun;
            win_d    = '0;
            tick_clr = 1'b1;
          end
        end
        StRun: begin
          if (!run) begin
            state_d = StHold;
          end else if (tick) begin
            if (sec_q != '0) begin
              sec_d = sec_q - 7'd1;
            end else begin
              sec_d = MaxSec;
              min_d = min_q - 7'd1;
            end
            win_d = (win_q == WinLast) ? '0 : win_q + WinW'(1);
            // 00:00 never occurs in RUN, so 00:01 is the only value that lands on zero.
            if (min_q == '0 && sec_q == 7'd1) begin
              state_d = StDone;
            end
          end
        end
        StHold: begin
          if (run) begin
            state_d = StRun;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    mag_d  = (state_d == StRun) && (32'(win_d) < on_seconds(power_d, WINDOW));
    busy_d = (state_d == StRun) || (state_d == StHold);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      min_q   <= '0;
      sec_q   <= '0;
      win_q   <= '0;
      power_q <= '0;
      mag_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      win_q   <= win_d;
      power_q <= power_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign min_out   = min_q;
  assign sec_out   = sec_q;
  assign magnetron = mag_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cook_scheduler.sv
// Scoreboard bench for cook_scheduler with CLK_HZ=4, WINDOW=8.
module tb_cook_scheduler;

  logic       clock = 1'b0;
  logic       reset, load, run, abort;
  logic [6:0] min_in, sec_in;
  logic [1:0] power_in;
  logic [6:0] min_out, sec_out;
  logic       magnetron, busy, done;

  always #5 clock = ~clock;

  cook_scheduler #(
    .CLK_HZ(4),
    .WINDOW(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .min_in   (min_in),
    .sec_in   (sec_in),
    .power_in (power_in),
    .run      (run),
    .abort    (abort),
    .min_out  (min_out),
    .sec_out  (sec_out),
    .magnetron(magnetron),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    string      name;
    logic [6:0] mn;
    logic [6:0] sc;
    logic       mag;
    logic       bsy;
    logic       dn;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input string name, input int mn, input int sc, input bit mag,
                      input bit bsy, input bit dn, input int at);
    exp_t e;
    e.name = name;
    e.mn   = 7'(mn);
    e.sc   = 7'(sc);
    e.mag  = mag;
    e.bsy  = bsy;
    e.dn   = dn;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // Monitor: compare whenever the outputs change, or when an entry falls due.
  logic [16:0] prev = 'x;
  always @(negedge clock) begin
    logic [16:0] obs;
    exp_t        e;
    obs = {min_out, sec_out, magnetron, busy, done};
    if (obs !== prev || (sb.size() > 0 && sb[0].at == cyc)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got %0d:%0d mag=%b busy=%b done=%b at cycle %0d, want no change",
                 min_out, sec_out, magnetron, busy, done, cyc);
      end else begin
        e = sb.pop_front();
        if (obs !== {e.mn, e.sc, e.mag, e.bsy, e.dn} || e.at != cyc) begin
          errors++;
          $display("FAIL %s: got %0d:%0d mag=%b busy=%b done=%b at cycle %0d, want %0d:%0d mag=%b busy=%b done=%b at cycle %0d",
                   e.name, min_out, sec_out, magnetron, busy, done, cyc,
                   e.mn, e.sc, e.mag, e.bsy, e.dn, e.at);
        end
      end
    end
    prev = obs;
  end

  initial begin
    int c;
    int n;
    reset = 1'b0; load = 1'b0; run = 1'b0; abort = 1'b0;
    min_in = '0; sec_in = '0; power_in = '0;

    // Reset held for two edges.
    push("reset edge1", 0, 0, 0, 0, 0, 1);
    push("reset edge2", 0, 0, 0, 0, 0, 2);
    wait_until(2);
    reset = 1'b1;

    // Clamp on capture.
    c = cyc;
    load = 1'b1; min_in = 7'd120; sec_in = 7'd75; power_in = 2'd0;
    push("clamp 99:59", 99, 59, 0, 0, 0, c + 1);
    step();
    load = 1'b0;

    // 01:05 at full power, counted all the way down.
    c = cyc;
    load = 1'b1; min_in = 7'd1; sec_in = 7'd5; power_in = 2'd3;
    push("load 01:05", 1, 5, 0, 0, 0, c + 1);
    step();
    load = 1'b0; run = 1'b1;
    n = c + 2;
    push("run start", 1, 5, 1, 1, 0, n);
    for (int k = 1; k <= 64; k++) begin
      push("countdown", (65 - k) / 60, (65 - k) % 60, 1, 1, 0, n + 4 * k);
    end
    push("done pulse", 0, 0, 0, 0, 1, n + 260);
    push("done ends", 0, 0, 0, 0, 0, n + 261);
    push("run at 00:00", 0, 0, 0, 0, 0, n + 265);
    wait_until(n + 266);
    run = 1'b0;

    // Hold with prescaler at 2, resume, load-in-run, abort+load.
    c = cyc;
    load = 1'b1; min_in = 7'd0; sec_in = 7'd10; power_in = 2'd3;
    push("load 00:10", 0, 10, 0, 0, 0, c + 1);
    step();
    load = 1'b0; run = 1'b1;
    n = c + 2;
    push("run 00:10", 0, 10, 1, 1, 0, n);
    push("enter hold", 0, 10, 0, 1, 0, n + 3);
    push("hold frozen", 0, 10, 0, 1, 0, n + 12);
    push("resume", 0, 10, 1, 1, 0, n + 23);
    push("resume tick", 0, 9, 1, 1, 0, n + 25);
    push("load ignored", 0, 8, 1, 1, 0, n + 29);
    push("abort+load", 0, 0, 0, 0, 0, n + 31);
    push("after abort", 0, 0, 0, 0, 0, n + 33);
    wait_until(n + 2);
    run = 1'b0;
    wait_until(n + 22);
    run = 1'b1;
    wait_until(n + 26);
    load = 1'b1; min_in = 7'd5; sec_in = 7'd5;
    step();
    load = 1'b0;
    wait_until(n + 30);
    abort = 1'b1; load = 1'b1; min_in = 7'd3; sec_in = 7'd3;
    step();
    abort = 1'b0; load = 1'b0; run = 1'b0;
    wait_until(n + 34);

    // Power 1: on for window seconds 0-3, off for 4-7.
    c = cyc;
    load = 1'b1; min_in = 7'd0; sec_in = 7'd20; power_in = 2'd1;
    push("load 00:20", 0, 20, 0, 0, 0, c + 1);
    step();
    load = 1'b0; run = 1'b1;
    n = c + 2;
    push("duty start", 0, 20, 1, 1, 0, n);
    for (int k = 1; k <= 19; k++) begin
      push("duty", 0, 20 - k, (k % 8) < 4, 1, 0, n + 4 * k);
    end
    push("duty done", 0, 0, 0, 0, 1, n + 80);
    push("duty idle", 0, 0, 0, 0, 0, n + 81);
    wait_until(n + 84);
    run = 1'b0;
    wait_until(n + 86);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got never checked, want check at cycle %0d", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
